dsram_pre: RTL and testbench

- Data-SRAM request stage of the EXU load/store path.
- Takes one load/store from EXU via valid/ready and aligns store data and byte strobes.
- Runs the request/response handshake to data SRAM and holds raw read word plus byte offset for dsram_post, which does load extraction and extension.
- Non-pipelined: one outstanding access.

---
 rtl/dsram_pre_pkg.sv | 46 ++++
 rtl/dsram_store_align.sv | 46 ++++
 rtl/dsram_pre.sv | 127 ++++++++++++
 tb/tb_dsram_pre.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsram_pre_pkg.sv
// Shared LSU op codes, reset level and FSM encodings for the data-SRAM request stage.
// Misaligned-access trapping is enabled by defining LSU_MISALIGN_CHK_EN.
package dsram_pre_pkg;

  localparam int unsigned LSU_OP_W = 4;
  typedef logic [LSU_OP_W-1:0] lsu_op_t;

  localparam lsu_op_t LSU_OP_NONE = 4'd0;
  localparam lsu_op_t LSU_OP_LB   = 4'd1;
  localparam lsu_op_t LSU_OP_LH   = 4'd2;
  localparam lsu_op_t LSU_OP_LW   = 4'd3;
  localparam lsu_op_t LSU_OP_LBU  = 4'd4;
  localparam lsu_op_t LSU_OP_LHU  = 4'd5;
  localparam lsu_op_t LSU_OP_SB   = 4'd6;
  localparam lsu_op_t LSU_OP_SH   = 4'd7;
  localparam lsu_op_t LSU_OP_SW   = 4'd8;

  localparam logic RST_ENABLE = 1'b1;

  localparam logic [1:0] DSRAM_PRE_IDLE = 2'd0;
  localparam logic [1:0] DSRAM_PRE_REQ  = 2'd1;
  localparam logic [1:0] DSRAM_PRE_RESP = 2'd2;
  localparam logic [1:0] DSRAM_PRE_DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = DSRAM_PRE_IDLE,
    StReq  = DSRAM_PRE_REQ,
    StResp = DSRAM_PRE_RESP,
    StDone = DSRAM_PRE_DONE
  } dsram_pre_state_e;

  function automatic logic is_load(lsu_op_t op);
    case (op)
      LSU_OP_LB, LSU_OP_LH, LSU_OP_LW, LSU_OP_LBU, LSU_OP_LHU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(lsu_op_t op);
    case (op)
      LSU_OP_SB, LSU_OP_SH, LSU_OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dsram_store_align.sv
// Combinational store alignment: byte strobes, shifted store data and misaligned flag.
// The misaligned flag is only live when LSU_MISALIGN_CHK_EN is defined; otherwise it is 0.
module dsram_store_align
  import dsram_pre_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  lsu_op_t             op_i,
  input  logic [1:0]          off_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic                misaligned_o
);

  localparam int unsigned StrbW = DATA_W / 8;

  always_comb begin
    wstrb_o      = '0;
    wdata_o      = '0;
    misaligned_o = 1'b0;

    // Upper strobe bits shifted past the word are dropped on purpose.
    case (op_i)
      LSU_OP_SB: wstrb_o = StrbW'(1) << off_i;
      LSU_OP_SH: wstrb_o = StrbW'(3) << off_i;
      LSU_OP_SW: wstrb_o = '1;
      default:   wstrb_o = '0;
    endcase

    if (is_store(op_i)) begin
      wdata_o = wdata_i << {off_i, 3'b000};
    end

`ifdef LSU_MISALIGN_CHK_EN
    case (op_i)
      LSU_OP_LH, LSU_OP_LHU, LSU_OP_SH: misaligned_o = off_i[0];
      LSU_OP_LW, LSU_OP_SW:             misaligned_o = |off_i;
      default:                          misaligned_o = 1'b0;
    endcase
`else
    misaligned_o = 1'b0;
`endif
  end

endmodule

// File: rtl/dsram_pre.sv
// Data-SRAM request stage: accepts one load/store, runs the SRAM req/resp handshake and holds
// the raw read word plus byte offset for dsram_post. LSU_MISALIGN_CHK_EN enables misalign traps.
module dsram_pre
  import dsram_pre_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  lsu_op_t             lsu_op_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                valid_o,
  input  logic                ready_i,
  output lsu_op_t             lsu_op_o,
  output logic [DATA_W-1:0]   roff_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_wen_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_resp_valid_i,
  output logic                mem_resp_ready_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                misalign_o
);

  dsram_pre_state_e    state_q;
  lsu_op_t             op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                misalign_q;

  lsu_op_t             align_op;
  logic [1:0]          align_off;
  logic [DATA_W/8-1:0] align_wstrb;
  logic [DATA_W-1:0]   align_wdata;
  logic                align_misaligned;
  logic                in_req;
  logic                op_known;

  // In IDLE the aligner looks at the incoming request so the misalign decision is made at
  // accept time; afterwards it works on the latched request for the SRAM payload.
  assign align_op  = (state_q == StIdle) ? lsu_op_i : op_q;
  assign align_off = (state_q == StIdle) ? addr_i[1:0] : addr_q[1:0];
  assign op_known  = is_load(lsu_op_i) | is_store(lsu_op_i);

  dsram_store_align #(
    .DATA_W (DATA_W)
  ) u_store_align (
    .op_i         (align_op),
    .off_i        (align_off),
    .wdata_i      (wdata_q),
    .wstrb_o      (align_wstrb),
    .wdata_o      (align_wdata),
    .misaligned_o (align_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= StIdle;
      op_q       <= LSU_OP_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            op_q    <= op_known ? lsu_op_i : LSU_OP_NONE;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            rdata_q <= '0;
            if (!op_known) begin
              state_q <= StDone;
            end else if (align_misaligned) begin
              state_q    <= StDone;
              misalign_q <= 1'b1;
            end else begin
              state_q <= StReq;
            end
          end
        end
        StReq: begin
          if (mem_req_ready_i) state_q <= StResp;
        end
        StResp: begin
          if (mem_resp_valid_i) begin
            rdata_q <= is_load(op_q) ? mem_rdata_i : '0;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (ready_i) begin
            state_q    <= StIdle;
            misalign_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_req           = (state_q == StReq);
  assign ready_o          = (state_q == StIdle);
  assign valid_o          = (state_q == StDone);
  assign mem_req_valid_o  = in_req;
  assign mem_resp_ready_o = (state_q == StResp);

  assign mem_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wen_o   = in_req & is_store(op_q);
  assign mem_wstrb_o = in_req ? align_wstrb : '0;
  assign mem_wdata_o = in_req ? align_wdata : '0;

  assign lsu_op_o   = op_q;
  assign roff_o     = {{(DATA_W-2){1'b0}}, addr_q[1:0]};
  assign rdata_o    = rdata_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_dsram_pre.sv
// Directed, table-driven bench for dsram_pre; expectations follow LSU_MISALIGN_CHK_EN if set.
module tb_dsram_pre;
  import dsram_pre_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  lsu_op_t     lsu_op_i = LSU_OP_NONE;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  lsu_op_t     lsu_op_o;
  logic [31:0] roff_o;
  logic [31:0] rdata_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_wen_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_resp_valid_i = 1'b0;
  logic        mem_resp_ready_o;
  logic [31:0] mem_rdata_i = '0;
  logic        misalign_o;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && mem_req_valid_o && mem_req_ready_i) hs_cnt <= hs_cnt + 1;
  end

  dsram_pre #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .lsu_op_i         (lsu_op_i),
    .addr_i           (addr_i),
    .wdata_i          (wdata_i),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .lsu_op_o         (lsu_op_o),
    .roff_o           (roff_o),
    .rdata_o          (rdata_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_wen_o        (mem_wen_o),
    .mem_wstrb_o      (mem_wstrb_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .mem_rdata_i      (mem_rdata_i),
    .misalign_o       (misalign_o)
  );

  typedef struct {
    lsu_op_t     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sram;
    int          req_wait;
    int          done_wait;
    logic        exp_req;
    logic [31:0] exp_maddr;
    logic        exp_wen;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_roff;
    lsu_op_t     exp_op;
    logic        exp_mis;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    string p;
    int hs0;
    p = $sformatf("v%0d", idx);
    valid_i  = 1'b1;
    lsu_op_i = v.op;
    addr_i   = v.addr;
    wdata_i  = v.wdata;
    chk({p, "_ready_idle"}, 32'(ready_o), 32'd1);
    hs0 = hs_cnt;
    tick();
    valid_i  = 1'b0;
    lsu_op_i = LSU_OP_NONE;
    addr_i   = '0;
    wdata_i  = '0;
    if (v.exp_req) begin
      for (int w = 0; w <= v.req_wait; w++) begin
        chk({p, "_req_valid"}, 32'(mem_req_valid_o), 32'd1);
        chk({p, "_valid_o_req"}, 32'(valid_o), 32'd0);
        chk({p, "_maddr"}, mem_addr_o, v.exp_maddr);
        chk({p, "_wen"}, 32'(mem_wen_o), 32'(v.exp_wen));
        chk({p, "_wstrb"}, 32'(mem_wstrb_o), 32'(v.exp_wstrb));
        chk({p, "_mwdata"}, mem_wdata_o, v.exp_mwdata);
        mem_req_ready_i = (w == v.req_wait);
        tick();
      end
      mem_req_ready_i = 1'b0;
      chk({p, "_resp_ready"}, 32'(mem_resp_ready_o), 32'd1);
      chk({p, "_req_valid_resp"}, 32'(mem_req_valid_o), 32'd0);
      chk({p, "_maddr_resp"}, mem_addr_o, 32'd0);
      chk({p, "_valid_o_resp"}, 32'(valid_o), 32'd0);
      mem_resp_valid_i = 1'b1;
      mem_rdata_i      = v.sram;
      tick();
      mem_resp_valid_i = 1'b0;
      mem_rdata_i      = '0;
    end
    chk({p, "_valid_o"}, 32'(valid_o), 32'd1);
    chk({p, "_ready_done"}, 32'(ready_o), 32'd0);
    chk({p, "_req_valid_done"}, 32'(mem_req_valid_o), 32'd0);
    chk({p, "_resp_ready_done"}, 32'(mem_resp_ready_o), 32'd0);
    chk({p, "_rdata"}, rdata_o, v.exp_rdata);
    chk({p, "_roff"}, roff_o, v.exp_roff);
    chk({p, "_lsu_op"}, 32'(lsu_op_o), 32'(v.exp_op));
    chk({p, "_misalign"}, 32'(misalign_o), 32'(v.exp_mis));
    for (int d = 0; d < v.done_wait; d++) begin
      tick();
      chk({p, "_valid_hold"}, 32'(valid_o), 32'd1);
      chk({p, "_ready_hold"}, 32'(ready_o), 32'd0);
      chk({p, "_rdata_hold"}, rdata_o, v.exp_rdata);
      chk({p, "_roff_hold"}, roff_o, v.exp_roff);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk({p, "_valid_after"}, 32'(valid_o), 32'd0);
    chk({p, "_ready_after"}, 32'(ready_o), 32'd1);
    chk({p, "_misalign_after"}, 32'(misalign_o), 32'd0);
    chk({p, "_handshakes"}, 32'(hs_cnt - hs0), 32'(v.exp_req));
  endtask

  initial begin
    // op, addr, wdata, sram, req_wait, done_wait,
    // exp_req, maddr, wen, wstrb, mwdata, rdata, roff, op_o, mis
    vecs[0] = '{LSU_OP_LW, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0,
                1'b1, 32'h8000_0004, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 32'd0, LSU_OP_LW, 1'b0};
    vecs[1] = '{LSU_OP_SB, 32'h8000_0003, 32'h0000_00A5, 32'h1111_1111, 0, 0,
                1'b1, 32'h8000_0000, 1'b1, 4'b1000, 32'hA500_0000, 32'h0, 32'd3, LSU_OP_SB, 1'b0};
    vecs[2] = '{LSU_OP_SH, 32'h8000_0002, 32'h0000_1234, 32'h2222_2222, 3, 0,
                1'b1, 32'h8000_0000, 1'b1, 4'b1100, 32'h1234_0000, 32'h0, 32'd2, LSU_OP_SH, 1'b0};
    vecs[3] = '{LSU_OP_LBU, 32'h0000_1001, 32'h0, 32'hCAFE_F00D, 0, 2,
                1'b1, 32'h0000_1000, 1'b0, 4'b0000, 32'h0, 32'hCAFE_F00D, 32'd1, LSU_OP_LBU, 1'b0};
    vecs[4] = '{LSU_OP_NONE, 32'h0000_0044, 32'h0000_0099, 32'h0, 0, 0,
                1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'd0, LSU_OP_NONE, 1'b0};
    vecs[5] = '{4'hF, 32'h0000_0013, 32'h0000_0077, 32'h0, 0, 1,
                1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'd3, LSU_OP_NONE, 1'b0};
    vecs[6] = '{LSU_OP_SW, 32'h0000_0100, 32'h89AB_CDEF, 32'h3333_3333, 1, 0,
                1'b1, 32'h0000_0100, 1'b1, 4'b1111, 32'h89AB_CDEF, 32'h0, 32'd0, LSU_OP_SW, 1'b0};
    vecs[7] = '{LSU_OP_SB, 32'h0000_2001, 32'h0000_005A, 32'h0, 0, 0,
                1'b1, 32'h0000_2000, 1'b1, 4'b0010, 32'h0000_5A00, 32'h0, 32'd1, LSU_OP_SB, 1'b0};
    vecs[8] = '{LSU_OP_LB, 32'h0000_0022, 32'h0, 32'h0BAD_F00D, 0, 0,
                1'b1, 32'h0000_0020, 1'b0, 4'b0000, 32'h0, 32'h0BAD_F00D, 32'd2, LSU_OP_LB, 1'b0};
`ifdef LSU_MISALIGN_CHK_EN
    vecs[9]  = '{LSU_OP_LW, 32'h0000_0002, 32'h0, 32'h7654_3210, 0, 0,
                 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'd2, LSU_OP_LW, 1'b1};
    vecs[10] = '{LSU_OP_SH, 32'h0000_0003, 32'h0000_1234, 32'h0, 0, 1,
                 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'd3, LSU_OP_SH, 1'b1};
    vecs[11] = '{LSU_OP_LH, 32'h0000_0041, 32'h0, 32'h1357_2468, 0, 0,
                 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'd1, LSU_OP_LH, 1'b1};
`else
    vecs[9]  = '{LSU_OP_LW, 32'h0000_0002, 32'h0, 32'h7654_3210, 0, 0,
                 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h7654_3210, 32'd2, LSU_OP_LW, 1'b0};
    vecs[10] = '{LSU_OP_SH, 32'h0000_0003, 32'h0000_1234, 32'h0, 0, 1,
                 1'b1, 32'h0, 1'b1, 4'b1000, 32'h3400_0000, 32'h0, 32'd3, LSU_OP_SH, 1'b0};
    vecs[11] = '{LSU_OP_LH, 32'h0000_0041, 32'h0, 32'h1357_2468, 0, 0,
                 1'b1, 32'h0000_0040, 1'b0, 4'b0000, 32'h0, 32'h1357_2468, 32'd1, LSU_OP_LH, 1'b0};
`endif

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_ready_o", 32'(ready_o), 32'd1);
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
    chk("rst_resp_ready", 32'(mem_resp_ready_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_roff", roff_o, 32'd0);
    chk("rst_lsu_op", 32'(lsu_op_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_maddr", mem_addr_o, 32'd0);

    // A response showing up while idle must be ignored.
    mem_resp_valid_i = 1'b1;
    mem_rdata_i      = 32'h5555_5555;
    chk("stray_resp_ready", 32'(mem_resp_ready_o), 32'd0);
    tick();
    mem_resp_valid_i = 1'b0;
    mem_rdata_i      = '0;
    chk("stray_rdata", rdata_o, 32'd0);
    chk("stray_valid_o", 32'(valid_o), 32'd0);
    chk("stray_ready_o", 32'(ready_o), 32'd1);

    for (int i = 0; i < NV; i++) begin
      run_txn(i, vecs[i]);
    end

    // Reset while waiting for the SRAM response.
    valid_i  = 1'b1;
    lsu_op_i = LSU_OP_LB;
    addr_i   = 32'h0000_0203;
    tick();
    valid_i  = 1'b0;
    lsu_op_i = LSU_OP_NONE;
    addr_i   = '0;
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    chk("rstmid_in_resp", 32'(mem_resp_ready_o), 32'd1);
    chk("rstmid_roff_before", roff_o, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_resp_ready", 32'(mem_resp_ready_o), 32'd0);
    chk("rstmid_valid_o", 32'(valid_o), 32'd0);
    chk("rstmid_ready_o", 32'(ready_o), 32'd1);
    chk("rstmid_lsu_op", 32'(lsu_op_o), 32'd0);
    chk("rstmid_roff", roff_o, 32'd0);
    run_txn(99, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
